spike_wave_gen: RTL



---
 rtl/spike_wave_gen.sv | 90 +++++++++
 1 files changed

// File: rtl/spike_wave_gen.sv
// Replays one accepted spike-time vector as a TIME_PERIOD-cycle raster; define SPIKE_HOLD_EN for step (hold-to-end) lines, else single-cycle pulses.
// Latency: wave starts the cycle after accept; backpressure: in_ready low through RUN and the one-cycle DONE gap.
module spike_wave_gen #(
   parameter int  NUM_SPIKES  = 16,
   parameter int  TIME_PERIOD = 8,
   localparam int TW          = $clog2(TIME_PERIOD) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_SPIKES*TW-1:0] spike_times,
   output logic [NUM_SPIKES-1:0]    spikes_out,
   output logic [TW-1:0]            time_val,
   output logic                     wave_valid,
   output logic                     done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state;
   logic [NUM_SPIKES*TW-1:0] t_reg;
   logic [TW-1:0]            next_t;
   logic                     last_t;
   logic [NUM_SPIKES-1:0]    hit_start;
   logic [NUM_SPIKES-1:0]    hit_next;

   assign next_t = time_val + TW'(1);
   assign last_t = (time_val == TW'(TIME_PERIOD - 1));

   // Full-width unsigned compares: times >= TIME_PERIOD can never match.
   always_comb begin
      hit_start = '0;
      hit_next  = '0;
      for (int i = 0; i < NUM_SPIKES; i++) begin
         hit_start[i] = (spike_times[i*TW +: TW] == '0);
         hit_next[i]  = (t_reg[i*TW +: TW] == next_t);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         t_reg      <= '0;
         in_ready   <= 1'b0;
         spikes_out <= '0;
         time_val   <= '0;
         wave_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  t_reg      <= spike_times;
                  time_val   <= '0;
                  wave_valid <= 1'b1;
                  spikes_out <= hit_start;
                  in_ready   <= 1'b0;
                  state      <= RUN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            RUN: begin
               if (last_t) begin
                  spikes_out <= '0;
                  wave_valid <= 1'b0;
                  time_val   <= '0;
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  time_val <= next_t;
`ifdef SPIKE_HOLD_EN
                  spikes_out <= spikes_out | hit_next;
`else
                  spikes_out <= hit_next;
`endif
               end
            end
            DONE: begin
               done     <= 1'b0;
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
